// File: rtl/tech_rst_seq.sv
// rtl/tech_rst_seq.sv - staged, synchronously released active-low reset sequencer
//
// Purpose: asserts all reset outputs asynchronously from the master reset and
// releases them one stage at a time, synchronised to clk, with HOLD cycles
// between releases. Optional four-phase software-reset handshake, compiled in
// when TECH_RST_SEQ_SWRST_EN is defined (otherwise sw_req is ignored and
// sw_ack is tied low; the port list is the same in both builds).
//
// Ports:
//   clk        in   1       single clock, all state on posedge
//   reset      in   1       asynchronous active-low master reset
//   sw_req     in   1       software reset request (four-phase, sync to clk)
//   sw_ack     out  1       software reset acknowledge
//   rst_n_out  out  STAGES  staged active-low resets, bit 0 released first
//   done       out  1       all stages released, sequencer in RUN
module tech_rst_seq #(
  parameter int STAGES     = 3,
  parameter int HOLD       = 4,
  parameter int SYNC_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_req,
  output logic              sw_ack,
  output logic [STAGES-1:0] rst_n_out,
  output logic              done
);

  localparam int CW = $clog2(HOLD + 1);
  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(HOLD - 1);
  localparam logic [IW-1:0] STAGE_LAST = IW'(STAGES - 1);

`ifdef TECH_RST_SEQ_SWRST_EN
  typedef enum logic [2:0] {
    ST_SYNC,
    ST_STRETCH,
    ST_RUN,
    ST_SWASSERT,
    ST_SWWAIT
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_SYNC,
    ST_STRETCH,
    ST_RUN
  } state_t;
`endif

  logic [SYNC_DEPTH-1:0] r_sync, w_sync_nxt;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_stage, w_stage_nxt;
  logic [STAGES-1:0]     r_rst_n, w_rst_n_nxt;
  logic                  r_done, w_done_nxt;

`ifdef TECH_RST_SEQ_SWRST_EN
  logic                  r_sw_ack, w_sw_ack_nxt;
`else
  logic                  w_sw_req_unused;
  assign w_sw_req_unused = sw_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync   <= '0;
      r_state  <= ST_SYNC;
      r_cnt    <= '0;
      r_stage  <= '0;
      r_rst_n  <= '0;
      r_done   <= 1'b0;
`ifdef TECH_RST_SEQ_SWRST_EN
      r_sw_ack <= 1'b0;
`endif
    end else begin
      r_sync   <= w_sync_nxt;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stage  <= w_stage_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_done   <= w_done_nxt;
`ifdef TECH_RST_SEQ_SWRST_EN
      r_sw_ack <= w_sw_ack_nxt;
`endif
    end
  end

  always_comb begin
    // The synchroniser always shifts in 1; only the master reset clears it.
    w_sync_nxt   = {r_sync[SYNC_DEPTH-2:0], 1'b1};
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stage_nxt  = r_stage;
    w_rst_n_nxt  = r_rst_n;
    w_done_nxt   = r_done;
`ifdef TECH_RST_SEQ_SWRST_EN
    w_sw_ack_nxt = r_sw_ack;
`endif

    case (r_state)
      ST_SYNC: begin
        // Leave SYNC on the same edge the last synchroniser flop loads its 1,
        // so counting starts at edge SYNC_DEPTH and stage k lands on
        // SYNC_DEPTH + (k+1)*HOLD.
        if (w_sync_nxt[SYNC_DEPTH-1]) begin
          w_state_nxt = ST_STRETCH;
          w_cnt_nxt   = '0;
        end
      end

      ST_STRETCH: begin
        if (r_cnt == CNT_LAST) begin
          for (int k = 0; k < STAGES; k++) begin
            if (IW'(k) == r_stage) begin
              w_rst_n_nxt[k] = 1'b1;
            end
          end
          w_cnt_nxt = '0;
          if (r_stage == STAGE_LAST) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_stage_nxt = r_stage + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_RUN: begin
`ifdef TECH_RST_SEQ_SWRST_EN
        if (sw_req) begin
          w_state_nxt = ST_SWASSERT;
          w_rst_n_nxt = '0;
          w_done_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end
`endif
      end

`ifdef TECH_RST_SEQ_SWRST_EN
      ST_SWASSERT: begin
        if (r_cnt == CNT_LAST) begin
          w_sw_ack_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_SWWAIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_SWWAIT: begin
        if (!sw_req) begin
          w_sw_ack_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_stage_nxt  = '0;
          w_state_nxt  = ST_STRETCH;
        end
      end
`endif

      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  assign rst_n_out = r_rst_n;
  assign done      = r_done;
`ifdef TECH_RST_SEQ_SWRST_EN
  assign sw_ack    = r_sw_ack;
`else
  assign sw_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_tech_rst_seq.sv
// tb/tb_tech_rst_seq.sv - self-checking bench for tech_rst_seq
module tb_tech_rst_seq;

  localparam int STAGES = 3;
  localparam int HOLD   = 4;
  localparam int SD     = 2;
  localparam int T_DONE = SD + STAGES * HOLD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sw_req = 1'b0;
  logic       sw_ack;
  logic [2:0] rst_n_out;
  logic       done;

  logic       sw_req1 = 1'b0;
  logic       sw_ack1;
  logic [0:0] rst1;
  logic       done1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tech_rst_seq #(.STAGES(STAGES), .HOLD(HOLD), .SYNC_DEPTH(SD)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_req    (sw_req),
    .sw_ack    (sw_ack),
    .rst_n_out (rst_n_out),
    .done      (done)
  );

  tech_rst_seq #(.STAGES(1), .HOLD(1), .SYNC_DEPTH(2)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .sw_req    (sw_req1),
    .sw_ack    (sw_ack1),
    .rst_n_out (rst1),
    .done      (done1)
  );

  typedef struct {
    string      tag;
    int         e;
    logic       req;
    logic [2:0] rst;
    logic       dn;
    logic       ack;
    logic       chk1;
    logic       r1;
  } vec_t;

  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stage k is released at edge base + (k+1)*HOLD.
  function automatic logic [2:0] exp_rst(input int e, input int base);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (e >= base + (k + 1) * HOLD) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic vec_t mk(input string tag, input int e, input logic req,
                              input logic [2:0] rst, input logic dn, input logic ack);
    vec_t v;
    v.tag  = tag;
    v.e    = e;
    v.req  = req;
    v.rst  = rst;
    v.dn   = dn;
    v.ack  = ack;
    v.chk1 = 1'b0;
    v.r1   = 1'b0;
    return v;
  endfunction

  // Drive one edge's inputs, queue its expectation, compare just after the edge.
  task automatic step(input vec_t v);
    vec_t x;
    sw_req = v.req;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check($sformatf("%s e%0d rst_n_out", x.tag, x.e), 32'(rst_n_out), 32'(x.rst));
    check($sformatf("%s e%0d done", x.tag, x.e), 32'(done), 32'(x.dn));
    check($sformatf("%s e%0d sw_ack", x.tag, x.e), 32'(sw_ack), 32'(x.ack));
    if (x.chk1) begin
      check($sformatf("%s e%0d s1 rst_n_out", x.tag, x.e), 32'(rst1), 32'(x.r1));
      check($sformatf("%s e%0d s1 done", x.tag, x.e), 32'(done1), 32'(x.r1));
      check($sformatf("%s e%0d s1 sw_ack", x.tag, x.e), 32'(sw_ack1), 32'(0));
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, " rst_n_out"}, 32'(rst_n_out), 32'(0));
    check({tag, " done"}, 32'(done), 32'(0));
    check({tag, " sw_ack"}, 32'(sw_ack), 32'(0));
    check({tag, " s1 rst_n_out"}, 32'(rst1), 32'(0));
    check({tag, " s1 done"}, 32'(done1), 32'(0));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;

    // Reset state
    reset  = 1'b0;
    sw_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_low("in_reset");
    @(negedge clk);
    reset = 1'b1;

    // Power-up release, both instances
    tbl = {};
    for (int e = 1; e <= 16; e++) begin
      v = mk("pwrup", e, 1'b0, exp_rst(e, SD), (e >= T_DONE), 1'b0);
      v.chk1 = 1'b1;
      v.r1   = (e >= 3);
      tbl.push_back(v);
    end
    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous assertion out of RUN, then restart
    reset = 1'b0;
    #1;
    check_all_low("async_from_run");
    @(negedge clk);
    reset = 1'b1;

    tbl = {};
    for (int e = 1; e <= 8; e++) begin
      tbl.push_back(mk("pre_pulse", e, 1'b0, exp_rst(e, SD), (e >= T_DONE), 1'b0));
    end
    foreach (tbl[i]) step(tbl[i]);

    // Reset pulse between edges 8 and 9, no clock edge while low
    #3;
    reset = 1'b0;
    #1;
    check_all_low("pulse_e8");
    #1;
    reset = 1'b1;

    tbl = {};
    for (int e = 1; e <= 16; e++) begin
      tbl.push_back(mk("post_pulse", e, 1'b0, exp_rst(e, SD), (e >= T_DONE), 1'b0));
    end
`ifdef TECH_RST_SEQ_SWRST_EN
    // sw_req sampled high at 20, low at 27
    for (int e = 17; e <= 40; e++) begin
      if (e < 20)
        tbl.push_back(mk("swrst", e, 1'b0, 3'b111, 1'b1, 1'b0));
      else if (e < 27)
        tbl.push_back(mk("swrst", e, 1'b1, 3'b000, 1'b0, (e >= 20 + HOLD)));
      else
        tbl.push_back(mk("swrst", e, 1'b0, exp_rst(e, 27), (e >= 27 + STAGES * HOLD), 1'b0));
    end
`else
    // sw_req high for 10 cycles in RUN has no effect
    for (int e = 17; e <= 32; e++) begin
      tbl.push_back(mk("swign", e, (e >= 20 && e < 30), 3'b111, 1'b1, 1'b0));
    end
`endif
    foreach (tbl[i]) step(tbl[i]);

    // sw_req held high from edge 2: ignored until RUN
    reset = 1'b0;
    #1;
    check_all_low("async_restart");
    @(negedge clk);
    reset = 1'b1;

    tbl = {};
    for (int e = 1; e <= 19; e++) begin
      if (e < 15)
        tbl.push_back(mk("early_req", e, (e >= 2), exp_rst(e, SD), (e >= T_DONE), 1'b0));
      else
`ifdef TECH_RST_SEQ_SWRST_EN
        tbl.push_back(mk("early_req", e, 1'b1, 3'b000, 1'b0, (e >= 15 + HOLD)));
`else
        tbl.push_back(mk("early_req", e, 1'b1, 3'b111, 1'b1, 1'b0));
`endif
    end
    foreach (tbl[i]) step(tbl[i]);

    sw_req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tech_rst_seq.md
# tech_rst_seq

Reset sequencer that generates staged, synchronously released active-low resets for downstream asynchronous-reset flops.
- Reset assertion to all outputs is asynchronous.
- Release is synchronised to clk and staged one domain at a time, with a programmable hold between stages.
- Supports a four-phase software-reset handshake.
- Sits at the top of each techmap simulation bench, driving the reset pins of the mapped register cells under test.

## Interface
Parameters:
- STAGES, 3 — number of independently released reset outputs (>=1).
- HOLD, 4 — clk cycles between successive releases and software-reset assert time (>=1).
- SYNC_DEPTH, 2 — flops in the deassertion synchroniser (>=2).

Ports:
- clk  input  1  — single clock, all state on posedge.
- reset  input  1  — asynchronous, active-low master reset.
- sw_req  input  1  — software reset request, synchronous to clk, four-phase.
- sw_ack  output  1  — software reset acknowledge.
- rst_n_out  output  STAGES  — active-low staged resets; bit 0 released first.
- done  output  1  — all stages released, sequencer in RUN.

## Operation
- reset low, at any time, immediately and asynchronously sets:
  - rst_n_out = 0, done = 0, sw_ack = 0;
  - synchroniser chain cleared, counter = 0, stage index = 0, state = SYNC.
- States: SYNC, STRETCH, RUN, SWASSERT, SWWAIT.
- SYNC: the synchroniser shifts a constant 1. When the last flop is 1, the next state is STRETCH with counter = 0.
- STRETCH:
  - Counter increments each cycle.
  - When counter reaches HOLD-1: set rst_n_out[stage] = 1, clear counter, increment stage.
  - On releasing stage STAGES-1: done = 1, state = RUN.
  - Released bits stay 1.
- RUN: holds outputs. sw_req = 1 sampled → SWASSERT. At the same edge, all rst_n_out = 0, done = 0, counter = 0, stage = 0.
- SWASSERT: counts HOLD cycles, then sw_ack = 1, state = SWWAIT.
- SWWAIT: holds sw_ack = 1 while sw_req = 1. When sw_req = 0 is sampled: sw_ack = 0, state = STRETCH, counter = 0.
- sw_req is ignored in SYNC and STRETCH; no request is queued.
- Counter width: $clog2(HOLD+1), saturation-free; it is cleared on every stage transition.
- reset low mid-sequence, or during a software reset, aborts everything; the full sequence restarts from SYNC on release.

## Timing
- Edge numbering: edge 1 is the first posedge after reset rises. Assumes reset meets recovery/removal timing.
- Synchroniser ready at edge SYNC_DEPTH.
- rst_n_out[k] rises at edge SYNC_DEPTH + (k+1)*HOLD.
- done rises at the same edge as rst_n_out[STAGES-1].
- Defaults: stages rise at edges 6, 10, 14; done at 14.
- Software reset, with sw_req sampled high at edge E:
  - rst_n_out = 0 and done = 0 at edge E;
  - sw_ack = 1 at edge E+HOLD.
- With sw_req sampled low at edge F: sw_ack = 0 at F, and rst_n_out[k] rises at F + (k+1)*HOLD.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- TECH_RST_SEQ_SWRST_EN defined:
  - the software-reset path (SWASSERT, SWWAIT, sw_ack) is compiled in as described above.
- Not defined:
  - SWASSERT and SWWAIT are removed;
  - sw_req is ignored;
  - sw_ack is tied to 0;
  - RUN is terminal until reset is asserted.
- The port list is identical in both builds.

## Test plan
- Defaults, reset low 3 cycles, then high: rst_n_out = 000 through edge 5; 001 at edge 6; 011 at 10; 111 at 14; done = 1 at 14.
- reset pulsed low between edges 8 and 9: rst_n_out = 000 and done = 0 immediately (no clock needed); after release, stages rise again at relative edges 6, 10, 14.
- SWRST_EN, in RUN, sw_req high at edge 20 and held:
  - rst_n_out = 000 and done = 0 at 20; sw_ack = 1 at 24;
  - sw_req dropped, sampled low at 27: sw_ack = 0 at 27; stages rise at 31, 35, 39.
- sw_req held high from edge 2 (during SYNC/STRETCH): no effect; normal release at 6/10/14; then SWASSERT entered at edge 15.
- SWRST_EN undefined, sw_req high in RUN for 10 cycles: rst_n_out stays 111, done stays 1, sw_ack stays 0.
- STAGES = 1, HOLD = 1, SYNC_DEPTH = 2: rst_n_out[0] and done rise at edge 3.
